imm_alu_ctrl_seq: RTL and testbench

- Hardwired control sequencer that drives the datapath control strobes for fetch plus the immediate-ALU class (addi, andi, ori).
- Replaces hand-driven T0..T5 strobes: it fetches, decodes IR[31:27], executes, and loops while `run` is held.
- Generalised over memory latency (wait-stretched T1) and ALU code width.
- Flags unsupported opcodes and halts cleanly.

---
 rtl/ctrl_seq_pkg.sv | 24 ++
 rtl/imm_alu_decode.sv | 25 ++
 rtl/imm_alu_ctrl_seq.sv | 179 +++++++++++++++++
 tb/tb_imm_alu_ctrl_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared types and encodings for the immediate-ALU control sequencer:
// state enum, supported opcodes and the ALU operation codes it emits.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6
  } state_t;

  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_INC = 5'b11111;

endpackage

// File: rtl/imm_alu_decode.sv
// Combinational opcode decode for the immediate-ALU class:
// flags supported opcodes and maps each to its ALU operation.
module imm_alu_decode
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W  = 5,
  parameter int ALU_W = 5
) (
  input  logic [OP_W-1:0]  op,
  output logic             valid,
  output logic [ALU_W-1:0] alu_code
);

  always_comb begin
    valid    = 1'b1;
    alu_code = '0;
    case (op)
      OP_W'(OP_ADDI): alu_code = ALU_W'(ALU_ADD);
      OP_W'(OP_ANDI): alu_code = ALU_W'(ALU_AND);
      OP_W'(OP_ORI):  alu_code = ALU_W'(ALU_OR);
      default:        valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_alu_ctrl_seq.sv
// Hardwired fetch/decode/execute sequencer for addi/andi/ori with a
// wait-stretched memory-read step. Optional retired-instruction counter
// is enabled by defining IMM_RETIRE_CNT_EN.
//
// state | meaning
// IDLE  | all strobes low, waiting for run
// T0    | PC to MAR, PC+1 into Z
// T1    | memory read (held MEM_WAIT extra cycles); Z to PC on first cycle
// T2    | MDR to IR
// T3    | decode; Rb to Y for legal ops, illegal pulse otherwise
// T4    | ALU(Y, C) into Z
// T5    | Z to Ra, done pulse, loop or go idle
module imm_alu_ctrl_seq
  import ctrl_seq_pkg::state_t, ctrl_seq_pkg::IDLE, ctrl_seq_pkg::T0,
         ctrl_seq_pkg::T1, ctrl_seq_pkg::T2, ctrl_seq_pkg::T3,
         ctrl_seq_pkg::T4, ctrl_seq_pkg::T5;
#(
  parameter int               OP_W     = 5,
  parameter int               ALU_W    = 5,
  parameter int               MEM_WAIT = 0,
  parameter logic [ALU_W-1:0] ALU_INC  = ALU_W'(ctrl_seq_pkg::ALU_INC)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic             stop,
  input  logic [31:0]      ir,
  output logic             PCOut,
  output logic             MARIn,
  output logic             ZIn,
  output logic             ZLoOut,
  output logic             PCIn,
  output logic             MDRIn,
  output logic             MDROut,
  output logic             IRIn,
  output logic             YIn,
  output logic             COut,
  output logic             memread,
  output logic             Gra,
  output logic             Grb,
  output logic             RIn,
  output logic             ROut,
  output logic [ALU_W-1:0] ALUCode,
  output logic             busy,
  output logic             done,
  output logic             illegal
`ifdef IMM_RETIRE_CNT_EN
  ,
  output logic [31:0]      retired
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt;
  logic             stop_pending;
  logic [OP_W-1:0]  op_q;
  logic [OP_W-1:0]  dec_op;
  logic             dec_valid;
  logic [ALU_W-1:0] dec_alu;
  logic             unused_ir;

  assign unused_ir = ^ir[31-OP_W:0];

  // One decoder serves both T3 (live IR) and T4 (latched opcode).
  assign dec_op = (state == T3) ? ir[31:32-OP_W] : op_q;

  imm_alu_decode #(.OP_W(OP_W), .ALU_W(ALU_W)) u_decode (
    .op       (dec_op),
    .valid    (dec_valid),
    .alu_code (dec_alu)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      stop_pending <= 1'b0;
      op_q         <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0)
        wait_cnt <= WAIT_INIT;
      else if (state == T1 && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (state == T3)
        op_q <= ir[31:32-OP_W];
      if ((state == T3 && !dec_valid) || (state == T5 && state_nxt == IDLE))
        stop_pending <= 1'b0;
      else if (stop && (state != IDLE || run))
        stop_pending <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    PCOut     = 1'b0;
    MARIn     = 1'b0;
    ZIn       = 1'b0;
    ZLoOut    = 1'b0;
    PCIn      = 1'b0;
    MDRIn     = 1'b0;
    MDROut    = 1'b0;
    IRIn      = 1'b0;
    YIn       = 1'b0;
    COut      = 1'b0;
    memread   = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    RIn       = 1'b0;
    ROut      = 1'b0;
    ALUCode   = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: if (run) state_nxt = T0;
      T0: begin
        PCOut     = 1'b1;
        MARIn     = 1'b1;
        ZIn       = 1'b1;
        ALUCode   = ALU_INC;
        state_nxt = T1;
      end
      T1: begin
        memread = 1'b1;
        MDRIn   = 1'b1;
        // wait_cnt still holds its load value only on the first T1 cycle
        if (wait_cnt == WAIT_INIT) begin
          ZLoOut = 1'b1;
          PCIn   = 1'b1;
        end
        if (wait_cnt == 4'd0) state_nxt = T2;
      end
      T2: begin
        MDROut    = 1'b1;
        IRIn      = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        if (dec_valid) begin
          Grb       = 1'b1;
          ROut      = 1'b1;
          YIn       = 1'b1;
          state_nxt = T4;
        end else begin
          illegal   = 1'b1;
          state_nxt = IDLE;
        end
      end
      T4: begin
        COut      = 1'b1;
        ZIn       = 1'b1;
        ALUCode   = dec_alu;
        state_nxt = T5;
      end
      T5: begin
        ZLoOut    = 1'b1;
        Gra       = 1'b1;
        RIn       = 1'b1;
        done      = 1'b1;
        state_nxt = (run && !stop_pending && !stop) ? T0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef IMM_RETIRE_CNT_EN
  always_ff @(posedge clock) begin
    if (clear)
      retired <= '0;
    else if (state == T5)
      retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_imm_alu_ctrl_seq.sv
// Scoreboard bench for imm_alu_ctrl_seq: two instances (MEM_WAIT 0 and 3),
// per-cycle expected strobe vectors queued by stimulus, popped by a monitor.
module tb_imm_alu_ctrl_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Observed vector: {PCOut,MARIn,ZIn,ZLoOut,PCIn,MDRIn,MDROut,IRIn,YIn,COut,
  //                   memread,Gra,Grb,RIn,ROut,busy,done,illegal,ALUCode[4:0]}
  localparam logic [22:0] M_PCOUT  = 23'h1 << 22;
  localparam logic [22:0] M_MARIN  = 23'h1 << 21;
  localparam logic [22:0] M_ZIN    = 23'h1 << 20;
  localparam logic [22:0] M_ZLO    = 23'h1 << 19;
  localparam logic [22:0] M_PCIN   = 23'h1 << 18;
  localparam logic [22:0] M_MDRIN  = 23'h1 << 17;
  localparam logic [22:0] M_MDROUT = 23'h1 << 16;
  localparam logic [22:0] M_IRIN   = 23'h1 << 15;
  localparam logic [22:0] M_YIN    = 23'h1 << 14;
  localparam logic [22:0] M_COUT   = 23'h1 << 13;
  localparam logic [22:0] M_MEMRD  = 23'h1 << 12;
  localparam logic [22:0] M_GRA    = 23'h1 << 11;
  localparam logic [22:0] M_GRB    = 23'h1 << 10;
  localparam logic [22:0] M_RIN    = 23'h1 << 9;
  localparam logic [22:0] M_ROUT   = 23'h1 << 8;
  localparam logic [22:0] M_BUSY   = 23'h1 << 7;
  localparam logic [22:0] M_DONE   = 23'h1 << 6;
  localparam logic [22:0] M_ILL    = 23'h1 << 5;

  localparam logic [22:0] E_IDLE = 23'h0;
  localparam logic [22:0] E_T0   = M_PCOUT | M_MARIN | M_ZIN | M_BUSY | 23'h1f;
  localparam logic [22:0] E_T1F  = M_MEMRD | M_MDRIN | M_ZLO | M_PCIN | M_BUSY;
  localparam logic [22:0] E_T1   = M_MEMRD | M_MDRIN | M_BUSY;
  localparam logic [22:0] E_T2   = M_MDROUT | M_IRIN | M_BUSY;
  localparam logic [22:0] E_T3   = M_GRB | M_ROUT | M_YIN | M_BUSY;
  localparam logic [22:0] E_T3X  = M_ILL | M_BUSY;
  localparam logic [22:0] E_T5   = M_ZLO | M_GRA | M_RIN | M_DONE | M_BUSY;

  localparam logic [31:0] IR_ADDI = {5'b01100, 4'd1, 4'd2, 19'd5};
  localparam logic [31:0] IR_ANDI = {5'b01101, 4'b0110, 4'b0110, 19'd7};
  localparam logic [31:0] IR_ORI  = {5'b01110, 4'd3, 4'd4, 19'h3};
  localparam logic [31:0] IR_BAD  = 32'h0000_0000;

  function automatic logic [22:0] e_t4(input logic [4:0] alu);
    return M_COUT | M_ZIN | M_BUSY | {18'h0, alu};
  endfunction

  logic [1:0]  clear_v = 2'b11;
  logic [1:0]  run_v   = 2'b11;
  logic [1:0]  stop_v  = 2'b00;
  logic [31:0] ir_v [2];
  logic [22:0] obs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic PCOut, MARIn, ZIn, ZLoOut, PCIn, MDRIn, MDROut, IRIn, YIn, COut;
    logic memread, Gra, Grb, RIn, ROut, busy, done, illegal;
    logic [4:0] ALUCode;
`ifdef IMM_RETIRE_CNT_EN
    logic [31:0] retired;
`endif
    imm_alu_ctrl_seq #(.MEM_WAIT((g == 0) ? 0 : 3)) u_dut (
      .clock   (clock),
      .clear   (clear_v[g]),
      .run     (run_v[g]),
      .stop    (stop_v[g]),
      .ir      (ir_v[g]),
      .PCOut   (PCOut),
      .MARIn   (MARIn),
      .ZIn     (ZIn),
      .ZLoOut  (ZLoOut),
      .PCIn    (PCIn),
      .MDRIn   (MDRIn),
      .MDROut  (MDROut),
      .IRIn    (IRIn),
      .YIn     (YIn),
      .COut    (COut),
      .memread (memread),
      .Gra     (Gra),
      .Grb     (Grb),
      .RIn     (RIn),
      .ROut    (ROut),
      .ALUCode (ALUCode),
      .busy    (busy),
      .done    (done),
      .illegal (illegal)
`ifdef IMM_RETIRE_CNT_EN
      ,
      .retired (retired)
`endif
    );
    assign obs[g] = {PCOut, MARIn, ZIn, ZLoOut, PCIn, MDRIn, MDROut, IRIn, YIn,
                     COut, memread, Gra, Grb, RIn, ROut, busy, done, illegal,
                     ALUCode};
  end

  logic [22:0] q0[$];
  logic [22:0] q1[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int exp_ret [2];

  always @(posedge clock) cyc_n <= cyc_n + 1;

  // Monitor: one expected vector per cycle per instance, compared mid-cycle.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clock);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if (obs[0] !== e) begin
          errors++;
          $display("FAIL dut0_strobes cycle %0d got=%h exp=%h", cyc_n, obs[0], e);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if (obs[1] !== e) begin
          errors++;
          $display("FAIL dut1_strobes cycle %0d got=%h exp=%h", cyc_n, obs[1], e);
        end
      end
    end
  end

  // Queue the expectation for the cycle just begun, then set inputs for the next edge.
  task automatic cyc(input int u, input logic [22:0] e, input logic r,
                     input logic s, input logic c);
    @(posedge clock);
    #1;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    run_v[u]   = r;
    stop_v[u]  = s;
    clear_v[u] = c;
  endtask

  // Full legal instruction T0..T5; called in the cycle before T0.
  task automatic run_instr(input int u, input logic [31:0] iv, input logic [4:0] alu,
                           input int waits, input logic r_mid, input logic r_t5,
                           input logic s_t1);
    ir_v[u] = iv;
    cyc(u, E_T0, r_mid, 1'b0, 1'b0);
    cyc(u, E_T1F, r_mid, s_t1, 1'b0);
    for (int w = 0; w < waits; w++) cyc(u, E_T1, r_mid, 1'b0, 1'b0);
    cyc(u, E_T2, r_mid, 1'b0, 1'b0);
    cyc(u, E_T3, r_mid, 1'b0, 1'b0);
    cyc(u, e_t4(alu), r_mid, 1'b0, 1'b0);
    cyc(u, E_T5, r_t5, 1'b0, 1'b0);
    exp_ret[u]++;
  endtask

  initial begin
    ir_v[0] = IR_BAD;
    ir_v[1] = IR_BAD;
    exp_ret[0] = 0;
    exp_ret[1] = 0;

    // Reset with run held high; T0 must follow the edge after clear falls.
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b1);
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b0);
    run_instr(0, IR_ANDI, 5'b00101, 0, 1'b0, 1'b0, 1'b0);
    cyc(0, E_IDLE, 1'b0, 1'b1, 1'b0);   // stop in IDLE is ignored
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b0);

    // Back-to-back addi, ori, andi with run held until the last T5.
    run_instr(0, IR_ADDI, 5'b00011, 0, 1'b1, 1'b1, 1'b0);
    run_instr(0, IR_ORI,  5'b00110, 0, 1'b1, 1'b1, 1'b0);
    run_instr(0, IR_ANDI, 5'b00101, 0, 1'b1, 1'b0, 1'b0);
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b0);

    // Stop pulsed in the second T1: idles after the second done despite run.
    run_instr(0, IR_ADDI, 5'b00011, 0, 1'b1, 1'b1, 1'b0);
    run_instr(0, IR_ORI,  5'b00110, 0, 1'b1, 1'b1, 1'b1);
    cyc(0, E_IDLE, 1'b0, 1'b0, 1'b0);

    // Run and stop together in IDLE: one instruction, then idle; pending then clear.
    cyc(0, E_IDLE, 1'b1, 1'b1, 1'b0);
    run_instr(0, IR_ORI, 5'b00110, 0, 1'b1, 1'b1, 1'b0);
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b0);
    run_instr(0, IR_ADDI, 5'b00011, 0, 1'b0, 1'b0, 1'b0);
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b0);

    // Illegal opcode with a stop pending: illegal in T3, then idle.
    ir_v[0] = IR_BAD;
    cyc(0, E_T0, 1'b0, 1'b0, 1'b0);
    cyc(0, E_T1F, 1'b0, 1'b1, 1'b0);
    cyc(0, E_T2, 1'b0, 1'b0, 1'b0);
    cyc(0, E_T3X, 1'b0, 1'b0, 1'b0);
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b0);
    // Pending stop was dropped by the illegal exit, so run keeps looping here.
    run_instr(0, IR_ANDI, 5'b00101, 0, 1'b1, 1'b1, 1'b0);
    run_instr(0, IR_ADDI, 5'b00011, 0, 1'b0, 1'b0, 1'b0);
    cyc(0, E_IDLE, 1'b1, 1'b0, 1'b0);

    // Clear asserted in T4: next cycle all zero, no RIn.
    ir_v[0] = IR_ADDI;
    cyc(0, E_T0, 1'b0, 1'b0, 1'b0);
    cyc(0, E_T1F, 1'b0, 1'b0, 1'b0);
    cyc(0, E_T2, 1'b0, 1'b0, 1'b0);
    cyc(0, E_T3, 1'b0, 1'b0, 1'b0);
    cyc(0, e_t4(5'b00011), 1'b0, 1'b0, 1'b1);
`ifdef IMM_RETIRE_CNT_EN
    checks++;
    if (g_dut[0].retired !== 32'(exp_ret[0])) begin
      errors++;
      $display("FAIL retired_count got=%0d exp=%0d", g_dut[0].retired, exp_ret[0]);
    end
`endif
    cyc(0, E_IDLE, 1'b0, 1'b0, 1'b0);
    cyc(0, E_IDLE, 1'b0, 1'b0, 1'b0);
    cyc(0, E_IDLE, 1'b0, 1'b0, 1'b0);

    // MEM_WAIT=3 instance: four memread cycles, PCIn only in the first, done in cycle 9.
    cyc(1, E_IDLE, 1'b1, 1'b0, 1'b1);
    cyc(1, E_IDLE, 1'b1, 1'b0, 1'b0);
    run_instr(1, IR_ORI, 5'b00110, 3, 1'b0, 1'b0, 1'b0);
    cyc(1, E_IDLE, 1'b0, 1'b0, 1'b0);
    cyc(1, E_IDLE, 1'b0, 1'b0, 1'b0);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q0.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
